// File: rtl/nested_counter_pkg.sv
// nested_counter_pkg: shared state encoding and default widths for nested_counter.
package nested_counter_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int unsigned DEF_BITS = 16;
    localparam int unsigned DEF_DIMS = 3;
endpackage

// File: rtl/counter_stage.sv
// counter_stage: one loop dimension; reloads or steps when carried into, flags when the next step passes the end.
module counter_stage
    import nested_counter_pkg::*;
#(
    parameter int unsigned Bits = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            adv,
    input  logic [Bits-1:0] init,
    input  logic [Bits-1:0] start_val,
    input  logic [Bits-1:0] end_val,
    input  logic [Bits-1:0] step,
    output logic [Bits-1:0] count,
    output logic            at_end
);
    logic [Bits:0] sum;
    // One extra bit so a sum that overflows Bits still compares as past the end
    assign sum = {1'b0, count} + {1'b0, step};
    assign at_end = (step == '0) | (sum > {1'b0, end_val});
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= init;
        else if (adv)
            count <= at_end ? start_val : sum[Bits-1:0];
    end
endmodule

// File: rtl/nested_counter.sv
// nested_counter: Dims-deep nested loop index generator with run handshake and one-shot/continuous passes.
// Define NESTED_COUNTER_CHECK_EN to compile config and enable-usage assertions.
module nested_counter
    import nested_counter_pkg::*;
#(
    parameter int unsigned Bits = DEF_BITS,
    parameter int unsigned Dims = DEF_DIMS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      en_i,
    input  logic                      continuous_i,
    input  logic [Dims-1:0][Bits-1:0] start_val_i,
    input  logic [Dims-1:0][Bits-1:0] end_val_i,
    input  logic [Dims-1:0][Bits-1:0] count_by_i,
    output logic [Dims-1:0][Bits-1:0] count_o,
    output logic                      busy_o,
    output logic                      last_o,
    output logic [Dims-1:0]           wrap_o,
    output logic                      done_o
);
    state_t state, nxt;
    logic cont;
    logic [Dims-1:0][Bits-1:0] cfg_start, cfg_end, cfg_step;
    logic [Dims-1:0] at_end, carry;
    logic step_ok, adv_ok, fin;

    assign busy_o = state == RUN;
    assign step_ok = busy_o & en_i;
    // A stop in the same cycle freezes the tuple instead of stepping it
    assign adv_ok = step_ok & ~stop_i;
    assign last_o = busy_o & (&at_end);
    assign fin = adv_ok & last_o;
    assign wrap_o = {Dims{step_ok}} & carry & at_end;

    always_comb begin
        carry = '0;
        carry[0] = 1'b1;
        for (int i = 1; i < Dims; i++)
            carry[i] = carry[i-1] & at_end[i-1];
    end

    genvar d;
    generate
        for (d = 0; d < Dims; d++) begin : g_dim
            counter_stage #(.Bits(Bits)) u_stage (
                .clk       (clk_i),
                .rst       (rst_i),
                .load      (start_i),
                .adv       (adv_ok & carry[d]),
                .init      (start_val_i[d]),
                .start_val (cfg_start[d]),
                .end_val   (cfg_end[d]),
                .step      (cfg_step[d]),
                .count     (count_o[d]),
                .at_end    (at_end[d])
            );
        end
    endgenerate

    always_comb begin
        nxt = state;
        nxt = start_i ? RUN : (busy_o & (stop_i | (fin & ~cont))) ? IDLE : state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            done_o <= 1'b0;
            cont <= 1'b0;
            cfg_start <= '0;
            cfg_end <= '0;
            cfg_step <= '0;
        end else begin
            state <= nxt;
            done_o <= step_ok & last_o & (start_i | ~stop_i);
            if (start_i) begin
                cont <= continuous_i;
                cfg_start <= start_val_i;
                cfg_end <= end_val_i;
                cfg_step <= count_by_i;
            end
        end
    end

`ifdef NESTED_COUNTER_CHECK_EN
    always @(posedge clk_i) begin
        if (!rst_i && start_i)
            for (int i = 0; i < Dims; i++) begin
                assert (end_val_i[i] >= start_val_i[i]) else $error("dim %0d: end below start", i);
                assert (count_by_i[i] != '0) else $error("dim %0d: zero step", i);
            end
        if (!rst_i)
            assert (!(en_i && state == IDLE)) else $error("en_i high while idle");
    end
`else
`endif
endmodule
